// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that shares the common data bus (CDB)
// between NUM_FU functional units. Each FU hands its result into a
// one-entry holding register through fu_valid/fu_ready. Each cycle one held
// result is chosen and broadcast on the registered cdb_* outputs.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   flush                 drops held results and the outgoing broadcast
//   fu_valid/fu_ready     per-FU handshake
//   fu_tag/fu_data        per-FU result, FU i at [i*W +: W]
//   cdb_valid/tag/data    registered broadcast
//   cdb_src               index of the FU that produced the broadcast
//   perf_bcast_cnt        broadcasts issued      (CDB_PERF_CNT_EN only)
//   perf_conflict_cnt     cycles with >= 2 holds (CDB_PERF_CNT_EN only)
//
// Optional build macro: CDB_PERF_CNT_EN adds the two performance counters.

module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    localparam int SRC_W = $clog2(NUM_FU)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
`ifdef CDB_PERF_CNT_EN
    output logic [31:0]              perf_bcast_cnt,
    output logic [31:0]              perf_conflict_cnt,
`endif
    output logic [SRC_W-1:0]         cdb_src
);

    logic [NUM_FU-1:0]             hold_valid_q, hold_valid_d;
    logic [NUM_FU-1:0][TAG_W-1:0]  hold_tag_q,   hold_tag_d;
    logic [NUM_FU-1:0][DATA_W-1:0] hold_data_q,  hold_data_d;
    logic [SRC_W-1:0]              rr_ptr_q,     rr_ptr_d;
    logic                          cdb_valid_q,  cdb_valid_d;
    logic [TAG_W-1:0]              cdb_tag_q,    cdb_tag_d;
    logic [DATA_W-1:0]             cdb_data_q,   cdb_data_d;
    logic [SRC_W-1:0]              cdb_src_q,    cdb_src_d;

    logic [NUM_FU-1:0] grant;
    logic              grant_vld;
    logic [SRC_W-1:0]  grant_idx;

    // Round-robin search starting at rr_ptr; first held entry wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!grant_vld && hold_valid_q[SRC_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
        grant = '0;
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

    // A granted slot frees up this cycle, so its FU can refill on the same
    // edge; this keeps a lone streaming FU at one result per cycle.
    assign fu_ready = ~hold_valid_q | grant;

    always_comb begin
        hold_valid_d = hold_valid_q & ~grant;
        hold_tag_d   = hold_tag_q;
        hold_data_d  = hold_data_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_tag_d[i]   = fu_tag[i*TAG_W +: TAG_W];
                hold_data_d[i]  = fu_data[i*DATA_W +: DATA_W];
            end
        end

        cdb_valid_d = grant_vld;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_vld) begin
            cdb_tag_d  = hold_tag_q[grant_idx];
            cdb_data_d = hold_data_q[grant_idx];
            cdb_src_d  = grant_idx;
            if (grant_idx == SRC_W'(NUM_FU - 1)) rr_ptr_d = '0;
            else rr_ptr_d = grant_idx + 1'b1;
        end

        // Flush wins over grants and accepts alike.
        if (flush) begin
            hold_valid_d = '0;
            cdb_valid_d  = 1'b0;
            cdb_tag_d    = cdb_tag_q;
            cdb_data_d   = cdb_data_q;
            cdb_src_d    = cdb_src_q;
            rr_ptr_d     = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= '0;
            hold_tag_q   <= '0;
            hold_data_q  <= '0;
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_src_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_tag_q   <= hold_tag_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

`ifdef CDB_PERF_CNT_EN
    logic [31:0] bcast_cnt_q,    bcast_cnt_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    // Counters survive flush; only reset clears them.
    always_comb begin
        int nheld;
        nheld = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (hold_valid_q[i]) nheld = nheld + 1;
        end
        bcast_cnt_d    = bcast_cnt_q + 32'(cdb_valid_d);
        conflict_cnt_d = conflict_cnt_q + 32'(nheld >= 2);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcast_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            bcast_cnt_q    <= bcast_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign perf_bcast_cnt    = bcast_cnt_q;
    assign perf_conflict_cnt = conflict_cnt_q;
`endif

endmodule
